// File: rtl/ysyx_24080006_sim_pkg.sv
// Shared types for the address guard: access kinds, region attributes,
// the region descriptor, the reset-time default address map and the range
// helpers the per-region comparator uses.
// Region bounds are held at MAX_AW bits so that one struct type serves every
// AW up to 64; narrower addresses are zero-extended before comparison.
package ysyx_24080006_sim_pkg;

  localparam int MAX_AW   = 64;
  localparam int DEF_NREG = 8;

  typedef enum logic [1:0] {
    ACC_LOAD  = 2'd0,
    ACC_STORE = 2'd1,
    ACC_FETCH = 2'd2,
    ACC_RSVD  = 2'd3
  } acc_kind_e;

  // Bit order matches cfg_attr: {en,r,w,x,perip}
  typedef struct packed {
    logic en;
    logic r;
    logic w;
    logic x;
    logic perip;
  } region_attr_t;

  typedef struct packed {
    region_attr_t      attr;
    logic [MAX_AW-1:0] base;
    logic [MAX_AW-1:0] limit;
  } region_t;

  localparam region_t DEFAULT_MAP [DEF_NREG] = '{
    '{attr: region_attr_t'(5'b11001), base: 64'h0200_0000, limit: 64'h0200_FFFF}, // CLINT
    '{attr: region_attr_t'(5'b11101), base: 64'h1000_0000, limit: 64'h1000_0FFF}, // UART
    '{attr: region_attr_t'(5'b11101), base: 64'h1000_2000, limit: 64'h1000_200F}, // GPIO
    '{attr: region_attr_t'(5'b11001), base: 64'h1001_1000, limit: 64'h1001_1007}, // PS2
    '{attr: region_attr_t'(5'b11101), base: 64'h2100_0000, limit: 64'h211F_FFFF}, // VGA
    '{attr: region_attr_t'(5'b11110), base: 64'h0F00_0000, limit: 64'h0F00_1FFF}, // SRAM
    '{attr: region_attr_t'(5'b11010), base: 64'h3000_0000, limit: 64'h30FF_FFFF}, // FLASH
    '{attr: region_attr_t'(5'b11110), base: 64'hA000_0000, limit: 64'hA3FF_FFFF}  // SDRAM
  };

  // Inclusive unsigned range test; an inverted range (lo > hi) never matches.
  function automatic logic in_range(input logic [MAX_AW-1:0] a,
                                    input logic [MAX_AW-1:0] lo,
                                    input logic [MAX_AW-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  function automatic logic kind_allowed(input region_attr_t attr, input acc_kind_e kind);
    logic ok;
    case (kind)
      ACC_LOAD:  ok = attr.r;
      ACC_STORE: ok = attr.w;
      ACC_FETCH: ok = attr.x;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_24080006_region_match.sv
// Single-region comparator.
//   region : descriptor (attr, base, limit)
//   addr   : zero-extended request address
//   kind   : access kind
//   hit    : region enabled and base <= addr <= limit
//   grant  : attribute permits this kind (meaningful only with hit)
//   perip  : peripheral flag, gated by hit
module ysyx_24080006_region_match
  import ysyx_24080006_sim_pkg::*;
(
  input  region_t           region,
  input  logic [MAX_AW-1:0] addr,
  input  acc_kind_e         kind,
  output logic              hit,
  output logic              grant,
  output logic              perip
);

  assign hit   = region.attr.en & in_range(addr, region.base, region.limit);
  assign grant = kind_allowed(region.attr, kind);
  assign perip = hit & region.attr.perip;

endmodule

// File: rtl/ysyx_24080006_addr_guard.sv
// Address guard: checks each request against a programmable region table,
// returns the verdict one cycle later through a single output register, and
// records the first fault plus a saturating fault count.
//   clock/reset       : clock, async active-high reset
//   req_*             : request (valid/ready, address, kind)
//   resp_*            : registered lookup result (valid/ready, ok, perip, idx)
//   cfg_*             : region table write port
//   fault_*           : sticky first-fault capture, counter, clear
module ysyx_24080006_addr_guard
  import ysyx_24080006_sim_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 32,
  parameter int CNTW = 16,
  localparam int IW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [1:0]      req_kind,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_ok,
  output logic            resp_perip,
  output logic [IW-1:0]   resp_idx,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [AW-1:0]   cfg_base,
  input  logic [AW-1:0]   cfg_limit,
  input  logic [4:0]      cfg_attr,
  output logic            fault_valid,
  output logic [AW-1:0]   fault_addr,
  output logic [1:0]      fault_kind,
  output logic [CNTW-1:0] fault_cnt,
  input  logic            fault_clr
);

  region_t           tbl [NREG];
  logic [NREG-1:0]   hit, grant, perip;
  logic [MAX_AW-1:0] addr_x;
  acc_kind_e         kind;

  assign addr_x = MAX_AW'(req_addr);
  assign kind   = acc_kind_e'(req_kind);

  for (genvar g = 0; g < NREG; g++) begin : g_match
    ysyx_24080006_region_match u_match (
      .region (tbl[g]),
      .addr   (addr_x),
      .kind   (kind),
      .hit    (hit[g]),
      .grant  (grant[g]),
      .perip  (perip[g])
    );
  end

  // Lowest index wins: scan downwards so the last assignment is the lowest hit.
  logic          sel_hit, sel_grant, sel_perip;
  logic [IW-1:0] sel_idx;
  always_comb begin
    sel_hit   = 1'b0;
    sel_grant = 1'b0;
    sel_perip = 1'b0;
    sel_idx   = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_hit   = 1'b1;
        sel_grant = grant[i];
        sel_perip = perip[i];
        sel_idx   = IW'(i);
      end
    end
  end

  logic accept, nxt_ok, fault;
  assign req_ready = !resp_valid | resp_ready;
  assign accept    = req_valid & req_ready;
  assign nxt_ok    = sel_hit & sel_grant;
  assign fault     = accept & !nxt_ok;

  // Table: lookups this cycle see the old contents, writes land at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        tbl[i] <= (i < DEF_NREG) ? DEFAULT_MAP[i % DEF_NREG] : region_t'('0);
    end else if (cfg_we && (int'(cfg_idx) < NREG)) begin
      tbl[cfg_idx] <= '{attr:  region_attr_t'(cfg_attr),
                        base:  MAX_AW'(cfg_base),
                        limit: MAX_AW'(cfg_limit)};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_ok    <= 1'b0;
      resp_perip <= 1'b0;
      resp_idx   <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_ok    <= nxt_ok;
      resp_perip <= sel_perip;
      resp_idx   <= sel_idx;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Clear takes precedence over the old state, but a fault in the same cycle
  // is still recorded as the first of the new epoch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_kind  <= '0;
      fault_cnt   <= '0;
    end else if (fault_clr) begin
      fault_valid <= fault;
      fault_cnt   <= fault ? CNTW'(1) : '0;
      if (fault) begin
        fault_addr <= req_addr;
        fault_kind <= req_kind;
      end
    end else if (fault) begin
      if (!fault_valid) begin
        fault_valid <= 1'b1;
        fault_addr  <= req_addr;
        fault_kind  <= req_kind;
      end
      if (fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_addr_guard.sv
// Randomized scoreboard bench for the address guard: a reference model of the
// region table and fault registers predicts each response when a request is
// accepted; a negedge monitor pops and compares when the DUT presents it.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_ysyx_24080006_addr_guard;

  logic        clock = 0;
  logic        reset = 1;
  logic        req_valid = 0, resp_ready = 1, cfg_we = 0, fault_clr = 0;
  logic [31:0] req_addr = 0, cfg_base = 0, cfg_limit = 0;
  logic [1:0]  req_kind = 0;
  logic [2:0]  cfg_idx = 0;
  logic [4:0]  cfg_attr = 0;
  logic        req_ready, resp_valid, resp_ok, resp_perip, fault_valid;
  logic [2:0]  resp_idx;
  logic [31:0] fault_addr;
  logic [1:0]  fault_kind;
  logic [15:0] fault_cnt;
  logic        req_ready2, resp_valid2, resp_ok2, resp_perip2, fault_valid2;
  logic [2:0]  resp_idx2;
  logic [31:0] fault_addr2;
  logic [1:0]  fault_kind2;
  logic [1:0]  fault_cnt2;

  always #5 clock = ~clock;

  ysyx_24080006_addr_guard u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_kind(req_kind),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ok(resp_ok),
    .resp_perip(resp_perip), .resp_idx(resp_idx),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .cfg_attr(cfg_attr),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_kind(fault_kind),
    .fault_cnt(fault_cnt), .fault_clr(fault_clr)
  );

  ysyx_24080006_addr_guard #(.CNTW(2)) u_dut2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready2), .req_addr(req_addr), .req_kind(req_kind),
    .resp_valid(resp_valid2), .resp_ready(resp_ready), .resp_ok(resp_ok2),
    .resp_perip(resp_perip2), .resp_idx(resp_idx2),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .cfg_attr(cfg_attr),
    .fault_valid(fault_valid2), .fault_addr(fault_addr2), .fault_kind(fault_kind2),
    .fault_cnt(fault_cnt2), .fault_clr(fault_clr)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit ok; bit perip; bit [2:0] idx; } exp_t;
  exp_t        exp_q[$];
  bit [31:0]   m_base [8];
  bit [31:0]   m_limit[8];
  bit [4:0]    m_attr [8];   // {en,r,w,x,perip}
  bit          m_fv;
  bit [31:0]   m_fa;
  bit [1:0]    m_fk;
  int          m_cnt, m_cnt2;

  function automatic void model_reset();
    bit [31:0] b [8] = '{32'h0200_0000, 32'h1000_0000, 32'h1000_2000, 32'h1001_1000,
                         32'h2100_0000, 32'h0F00_0000, 32'h3000_0000, 32'hA000_0000};
    bit [31:0] l [8] = '{32'h0200_FFFF, 32'h1000_0FFF, 32'h1000_200F, 32'h1001_1007,
                         32'h211F_FFFF, 32'h0F00_1FFF, 32'h30FF_FFFF, 32'hA3FF_FFFF};
    bit [4:0]  a [8] = '{5'b11001, 5'b11101, 5'b11101, 5'b11001,
                         5'b11101, 5'b11110, 5'b11010, 5'b11110};
    for (int i = 0; i < 8; i++) begin
      m_base[i] = b[i]; m_limit[i] = l[i]; m_attr[i] = a[i];
    end
    m_fv = 0; m_fa = 0; m_fk = 0; m_cnt = 0; m_cnt2 = 0;
  endfunction

  function automatic exp_t lookup(input bit [31:0] addr, input bit [1:0] kind);
    exp_t e = '{ok: 0, perip: 0, idx: 0};
    for (int i = 0; i < 8; i++) begin
      if (m_attr[i][4] && addr >= m_base[i] && addr <= m_limit[i]) begin
        bit perm = (kind == 0) ? m_attr[i][3] : (kind == 1) ? m_attr[i][2] :
                   (kind == 2) ? m_attr[i][1] : 1'b0;
        e.ok = perm; e.perip = m_attr[i][0]; e.idx = 3'(i);
        return e;
      end
    end
    return e;
  endfunction

  // Monitor + model, one process so push/pop ordering is deterministic.
  bit        stall_prev = 0;
  bit [4:0]  held;
  exp_t      m_e, m_x;
  bit        m_acc, m_flt;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      model_reset();
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", resp_valid, 1);
        chk("stall_hold", {resp_ok, resp_perip, resp_idx}, held);
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          m_e = exp_q[0];
          chk("resp_ok", resp_ok, m_e.ok);
          chk("resp_perip", resp_perip, m_e.perip);
          chk("resp_idx", resp_idx, m_e.idx);
          if (resp_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("resp_missing", exp_q.size(), 0);
      end
      stall_prev = resp_valid && !resp_ready;
      held = {resp_ok, resp_perip, resp_idx};

      chk("fault_valid", fault_valid, m_fv);
      chk("fault_cnt", fault_cnt, m_cnt);
      chk("fault_cnt2", fault_cnt2, m_cnt2);
      if (m_fv) begin
        chk("fault_addr", fault_addr, m_fa);
        chk("fault_kind", fault_kind, m_fk);
      end
      chk("req_ready", req_ready, !resp_valid || resp_ready);

      m_acc = req_valid && (exp_q.size() == 0 || resp_ready);
      m_flt = 0;
      if (m_acc) begin
        m_x = lookup(req_addr, req_kind);
        exp_q.push_back(m_x);
        m_flt = !m_x.ok;
      end
      if (fault_clr) begin
        m_fv = m_flt; m_cnt = m_flt; m_cnt2 = m_flt;
        if (m_flt) begin m_fa = req_addr; m_fk = req_kind; end
      end else if (m_flt) begin
        if (!m_fv) begin m_fv = 1; m_fa = req_addr; m_fk = req_kind; end
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (cfg_we) begin
        m_base[cfg_idx] = cfg_base; m_limit[cfg_idx] = cfg_limit; m_attr[cfg_idx] = cfg_attr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1; req_valid = 0; cfg_we = 0; fault_clr = 0; resp_ready = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic req(input bit [31:0] a, input bit [1:0] k);
    req_valid = 1; req_addr = a; req_kind = k;
    tick();
    req_valid = 0;
  endtask

  function automatic bit [31:0] pick_addr();
    int r = $urandom_range(0, 7);
    case ($urandom_range(0, 5))
      0: return m_base[r] - 1;
      1: return m_base[r];
      2: return m_limit[r];
      3: return m_limit[r] + 1;
      4: return m_base[r] + ($urandom & 32'hFF);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit [1:0] sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_fault_valid", fault_valid, 0);
    chk("rst_fault_cnt", fault_cnt, 0);

    req(32'h1000_0000, 2'd0);
    chk("uart_valid", resp_valid, 1);
    chk("uart_ok", resp_ok, 1);
    chk("uart_idx", resp_idx, 1);
    chk("uart_perip", resp_perip, 1);

    req(32'h3000_0010, 2'd1);
    chk("flash_st_ok", resp_ok, 0);
    chk("flash_st_idx", resp_idx, 6);
    chk("flash_fv", fault_valid, 1);
    chk("flash_fa", fault_addr, 32'h3000_0010);
    chk("flash_fk", fault_kind, 1);
    chk("flash_cnt", fault_cnt, 1);

    req(32'h0200_FFFF, 2'd0);
    chk("clint_hi_ok", resp_ok, 1);
    chk("clint_hi_idx", resp_idx, 0);
    req(32'h0201_0000, 2'd0);
    chk("clint_miss_ok", resp_ok, 0);
    chk("clint_miss_idx", resp_idx, 0);
    chk("clint_miss_perip", resp_perip, 0);

    // Back-pressure: nothing may be accepted, no fault counted.
    resp_ready = 0; req_valid = 1; req_addr = 32'h0; req_kind = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", req_ready, 0);
      tick();
      chk("stall_cnt", fault_cnt, 2);
    end
    req_valid = 0; resp_ready = 1;
    tick();

    // Same-cycle table write must not affect the concurrent lookup.
    cfg_we = 1; cfg_idx = 3'd7; cfg_base = 32'hA000_0000; cfg_limit = 32'hA3FF_FFFF;
    cfg_attr = 5'b01110;
    req(32'hA000_0000, 2'd0);
    cfg_we = 0;
    chk("cfg_same_ok", resp_ok, 1);
    chk("cfg_same_idx", resp_idx, 7);
    req(32'hA000_0000, 2'd0);
    chk("cfg_after_ok", resp_ok, 0);

    // Counter saturation on the 2-bit instance, then clear with a fault.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req(32'h100 + i, 2'd3);
      chk("sat_cnt2", fault_cnt2, sat[i]);
      chk("sat_cnt16", fault_cnt, i + 1);
    end
    chk("sat_fa", fault_addr, 32'h100);
    fault_clr = 1;
    req(32'h1234_5678, 2'd3);
    fault_clr = 0;
    chk("clr_cnt2", fault_cnt2, 1);
    chk("clr_cnt16", fault_cnt, 1);
    chk("clr_fa", fault_addr, 32'h1234_5678);
    chk("clr_fv", fault_valid, 1);
    tick();

    // Randomized traffic with table rewrites, back-pressure and clears.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = pick_addr();
      req_kind   = 2'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 3) != 0);
      fault_clr  = ($urandom_range(0, 40) == 0);
      cfg_we     = ($urandom_range(0, 15) == 0);
      cfg_idx    = 3'($urandom_range(0, 7));
      cfg_base   = pick_addr() & 32'hFFFF_FF00;
      cfg_limit  = ($urandom_range(0, 9) == 0) ? cfg_base - 1 : cfg_base + $urandom_range(0, 32'h1FFF);
      cfg_attr   = 5'($urandom) | (($urandom_range(0, 4) != 0) ? 5'b10000 : 5'b00000);
      tick();
    end
    req_valid = 0; cfg_we = 0; fault_clr = 0; resp_ready = 1;
    tick();

    // Reset while a response is pending: it is dropped with no handshake.
    resp_ready = 0;
    req(32'h1000_0000, 2'd0);
    chk("pend_valid", resp_valid, 1);
    #2 reset = 1;
    #1 chk("rst_drop_valid", resp_valid, 0);
    chk("rst_drop_ready", req_ready, 1);
    @(posedge clock); #1 reset = 0; resp_ready = 1;
    repeat (3) tick();
    chk("post_rst_valid", resp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_addr_guard.md
YSYX_24080006_ADDR_GUARD -- requirements
Module: ysyx_24080006_addr_guard

Interface
REQ-001 SHALL have parameter NREG, default 8, number of address regions (1..16).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter CNTW, default 16, fault counter width.
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1, req_addr input AW, req_kind input 2: access request (LOAD=0, STORE=1, FETCH=2; 3 reserved, always faults).
REQ-007 SHALL have ports resp_valid output 1, resp_ready input 1, resp_ok output 1, resp_perip output 1, resp_idx output IW=max(1,$clog2(NREG)): lookup result.
REQ-008 SHALL have ports cfg_we input 1, cfg_idx input IW, cfg_base input AW, cfg_limit input AW, cfg_attr input 5 {en,r,w,x,perip}: region table write.
REQ-009 SHALL have ports fault_valid output 1, fault_addr output AW, fault_kind output 2, fault_cnt output CNTW, fault_clr input 1: fault capture.

Function
REQ-010 SHALL hit region i when attr.en and base_i <= addr <= limit_i (unsigned, inclusive both ends); base > limit never hits.
REQ-011 SHALL select the lowest-index hit when regions overlap.
REQ-012 SHALL grant: LOAD needs r, STORE needs w, FETCH needs x; resp_ok=1 only on hit and grant.
REQ-013 SHALL set resp_idx=hit index and resp_perip=attr.perip on hit; both 0 on miss.
REQ-014 SHALL register the result: request accepted in cycle N (req_valid & req_ready) presents resp_valid in cycle N+1; latency exactly 1.
REQ-015 SHALL drive req_ready = !resp_valid | resp_ready (single output stage, back-to-back throughput 1/cycle).
REQ-016 SHALL hold resp_* stable while resp_valid & !resp_ready.
REQ-017 SHALL evaluate lookups against the table as of the start of the cycle; a cfg write in the same cycle affects only later requests.
REQ-018 SHALL ignore cfg_we when cfg_idx >= NREG.
REQ-019 SHALL treat an accepted request with resp_ok=0 as a fault at acceptance time.
REQ-020 SHALL capture fault_addr/fault_kind and set fault_valid only on the first fault while fault_valid=0 (sticky, later faults do not overwrite).
REQ-021 SHALL increment fault_cnt per fault, saturating at all-ones.
REQ-022 SHALL on fault_clr clear fault_valid and fault_cnt; if a fault occurs in the same cycle, the new fault is captured and fault_cnt=1.

Reset
REQ-023 SHALL reset resp_valid, resp_ok, resp_perip, resp_idx, fault_valid, fault_addr, fault_kind, fault_cnt to 0; req_ready reads 1 after reset.
REQ-024 SHALL reset the table to the default map, index order: 0 CLINT 0x0200_0000-0x0200_FFFF r,perip; 1 UART 0x1000_0000-0x1000_0FFF rw,perip; 2 GPIO 0x1000_2000-0x1000_200F rw,perip; 3 PS2 0x1001_1000-0x1001_1007 r,perip; 4 VGA 0x2100_0000-0x211F_FFFF rw,perip; 5 SRAM 0x0F00_0000-0x0F00_1FFF rwx; 6 FLASH 0x3000_0000-0x30FF_FFFF rx; 7 SDRAM 0xA000_0000-0xA3FF_FFFF rwx; all en=1.
REQ-025 SHALL truncate the default map when NREG<8 and reset entries >=8 to en=0, base=limit=0.
REQ-026 SHALL on reset mid-transaction drop any pending response without handshake.

Structure
REQ-027 SHALL place acc_kind_e, region_attr_t, region_t and the default map constant array in ysyx_24080006_sim_pkg alongside the existing range helpers.
REQ-028 SHALL implement per-region compare in one sub-module ysyx_24080006_region_match (region_t, addr, kind -> hit, grant), instantiated NREG times; priority encode in the parent.

Verification
REQ-029 Reset, LOAD 0x1000_0000 -> next cycle resp_valid=1, resp_ok=1, resp_idx=1, resp_perip=1.
REQ-030 STORE 0x3000_0010 -> resp_ok=0, resp_idx=6; fault_valid=1, fault_addr=0x3000_0010, fault_kind=1, fault_cnt=1.
REQ-031 LOAD 0x0200_FFFF then 0x0201_0000 -> ok=1 idx=0, then ok=0 idx=0 perip=0 (boundary, miss).
REQ-032 resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, resp_* stable, no accepted requests, no extra fault counts.
REQ-033 cfg write idx 7 {en=0} same cycle as LOAD 0xA000_0000 -> that request ok=1; repeat next cycle -> ok=0.
REQ-034 CNTW=2, 5 faults then fault_clr with simultaneous fault -> fault_cnt 1,2,3,3,3 then 1, fault_addr = new address.
